io_btn_debounce: RTL
====================

Name: io_btn_debounce

Overview:
- Sits directly downstream of the I2C expander poller on the board-I/O path.
- Consumes its raw `btn[2:0]` and `sd_cd` samples (refreshed only every few hundred µs, possibly glitchy).
- Produces debounced button levels, one-cycle press/release/long-press events, and debounced SD-card presence with insert/remove events for the HPS/OSD logic.
- Purely same-clock-domain; no synchronisers required.

Parameters:
- CLK_HZ, 50_000_000, clock frequency; ms prescaler divides by CLK_HZ/1000.
- DEBOUNCE_MS, 20, consecutive ms a new input level must persist before commit; legal range 1..255.
- LONG_MS, 1000, ms a button must stay pressed (counted from press commit) before the long event; must exceed DEBOUNCE_MS; max 65535.
- REPEAT_MS, 100, auto-repeat period; only used with AUTO_REPEAT_EN; legal range 1..65535.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous active-low reset.
- btn_raw, input, 3: raw button levels, 1 = pressed.
- sd_cd_raw, input, 1: raw card-detect, 1 = no card, 0 = card inserted.
- btn_state, output, 3: debounced button levels.
- btn_press, output, 3: one-clk pulse per bit on press commit.
- btn_release, output, 3: one-clk pulse per bit on release commit.
- btn_long, output, 3: one-clk pulse per bit when held LONG_MS.
- sd_present, output, 1: debounced card present, 1 = card.
- sd_insert, output, 1: one-clk pulse on present commit 0->1.
- sd_remove, output, 1: one-clk pulse on present commit 1->0.

Behaviour:
- **Reset** (reset_n=0 at posedge clk): all outputs 0, prescaler 0, all per-channel counters 0. Reset mid-hold or mid-debounce discards progress; no pulses are emitted on reset entry or exit.
- **Prescaler:** counts 0..CLK_HZ/1000-1. The internal `tick` is high for one clk in the cycle the count equals the terminal value, after which the count wraps to 0.
- **Input registering:**
  - Raw inputs are registered once.
  - sd channel internal level = ~sd_cd_raw_q.
  - 4 identical debounce channels: 3 buttons + sd.
- **Debounce channel** (8-bit ms counter `dcnt`):
  - If sampled level == committed state: dcnt <= 0, regardless of tick.
  - Else, on tick: if dcnt == DEBOUNCE_MS-1, committed state flips and dcnt <= 0; otherwise dcnt <= dcnt+1.
  - A single mismatching sample between ticks restarts nothing; only the equal condition clears dcnt.
  - Commit latency: between DEBOUNCE_MS-1 and DEBOUNCE_MS ms after the first differing sample, plus 1 clk for input registering.
- **Event pulses:**
  - btn_press/btn_release/sd_insert/sd_remove assert in the same clk the committed state changes, for exactly one clk.
  - Multiple channels may pulse in the same clk.
- **Long-press counter** (16-bit per button, `hcnt`):
  - Cleared to 0 on press commit.
  - Increments on each tick while btn_state=1, saturating at LONG_MS.
  - btn_long pulses once, in the clk hcnt transitions to LONG_MS.
  - Cleared on release commit.
  - If release commit and the LONG_MS transition coincide in the same clk, release wins: btn_release pulses and btn_long does not.
- **Wrap-around:** hcnt never wraps (saturation); dcnt never exceeds DEBOUNCE_MS-1.

Optional Feature:
- Macro: IO_BTN_AUTO_REPEAT_EN.
- **Defined:**
  - After btn_long fires, a per-button 16-bit repeat counter starts at 0.
  - It increments on ticks while btn_state=1.
  - When it reaches REPEAT_MS-1 on a tick, btn_press re-pulses for one clk and the counter reloads 0.
  - Release commit clears the counter, and no repeat pulse is issued in the same clk as a release.
- **Undefined:** no repeat counters are synthesised; btn_press fires only on press commit.

Test Plan:
- All directed runs use CLK_HZ=10_000 (tick every 10 clk), DEBOUNCE_MS=3, LONG_MS=10, REPEAT_MS=4.
1. Reset then idle with btn_raw=0, sd_cd_raw=1 for 200 clk -> all outputs remain 0; no pulses on reset release.
2. btn_raw[1] 0->1 held -> btn_state[1] rises within 21..31 clk after the input edge; btn_press=3'b010 for exactly 1 clk; btn_release stays 0.
3. btn_raw[0] toggled 1 clk high every 15 clk, for 300 clk -> btn_state[0] and all pulses stay 0.
4. btn_raw[2] held high 200 clk -> btn_long[2] pulses once, 10 ticks (100 clk ±10) after press commit. Then release -> btn_release[2] once and no further btn_long.
5. sd_cd_raw 1->0 held 50 clk, then 0->1 held 50 clk -> sd_present 0->1 with sd_insert 1 clk, then 1->0 with sd_remove 1 clk. Assert reset_n=0 mid-debounce in a repeat run -> sd_present=0 and no pulse.
6. With IO_BTN_AUTO_REPEAT_EN defined, btn_raw[0] held 300 clk -> one btn_press at commit, btn_long at +100 clk, then btn_press every 40 clk until release; none with the macro undefined.

Source files
------------

// File: rtl/io_btn_debounce_if.sv
// io_btn_debounce_if: raw button/card-detect samples in, debounced levels and events out
interface io_btn_debounce_if;
  logic [2:0] btn_raw;
  logic       sd_cd_raw;
  logic [2:0] btn_state;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic [2:0] btn_long;
  logic       sd_present;
  logic       sd_insert;
  logic       sd_remove;
  modport master (
    output btn_raw, sd_cd_raw,
    input  btn_state, btn_press, btn_release, btn_long, sd_present, sd_insert, sd_remove
  );
  modport slave (
    input  btn_raw, sd_cd_raw,
    output btn_state, btn_press, btn_release, btn_long, sd_present, sd_insert, sd_remove
  );
endinterface

// File: rtl/io_btn_debounce.sv
// io_btn_debounce: ms-tick debouncer for 3 buttons + SD card detect; optional auto-repeat via IO_BTN_AUTO_REPEAT_EN
module io_btn_debounce #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 100
) (
  input logic clk,
  input logic reset_n,
  io_btn_debounce_if.slave bus
);
  localparam int PRE = CLK_HZ / 1000;
  localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(PRE - 1);
  localparam logic [7:0] DB_TC = 8'(DEBOUNCE_MS - 1);
  localparam logic [15:0] LONG_V = 16'(LONG_MS);
  localparam logic [15:0] LONG_TC = 16'(LONG_MS - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [2:0]    btn_raw_q;
  logic          sd_cd_raw_q;
  logic [3:0]    lvl, flip, rise, fall;
  logic [3:0]    state_q, state_d;
  logic [7:0]    dcnt_q [4];
  logic [7:0]    dcnt_d [4];
  logic [15:0]   hcnt_q [3];
  logic [15:0]   hcnt_d [3];
  logic [2:0]    rep;
  logic [2:0]    press_q, press_d, release_q, release_d, long_q, long_d;
  logic          insert_q, insert_d, remove_q, remove_d;
`ifdef IO_BTN_AUTO_REPEAT_EN
  localparam logic [15:0] REP_TC = 16'(REPEAT_MS - 1);
  logic [15:0]   rcnt_q [3];
  logic [15:0]   rcnt_d [3];
`endif
  // Millisecond prescaler: tick marks the terminal count
  always_comb begin
    tick = pre_q == PRE_TC;
    pre_d = tick ? '0 : pre_q + 1'b1;
  end
  // Debounce channels: bit 3 is card presence (card detect is active low)
  always_comb begin
    lvl = {~sd_cd_raw_q, btn_raw_q};
    for (int i = 0; i < 4; i++) begin
      flip[i] = (lvl[i] != state_q[i]) && tick && (dcnt_q[i] == DB_TC);
      dcnt_d[i] = (lvl[i] == state_q[i] || flip[i]) ? 8'd0 : tick ? dcnt_q[i] + 8'd1 : dcnt_q[i];
    end
    state_d = state_q ^ flip;
    rise = flip & ~state_q;
    fall = flip & state_q;
  end
  // Hold timing per button: long-press pulse, release commit wins over it
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hcnt_d[i] = flip[i] ? 16'd0 : (state_q[i] && tick && hcnt_q[i] != LONG_V) ? hcnt_q[i] + 16'd1 : hcnt_q[i];
      long_d[i] = state_q[i] && !flip[i] && tick && (hcnt_q[i] == LONG_TC);
    end
  end
`ifdef IO_BTN_AUTO_REPEAT_EN
  // Auto-repeat: counts ticks once the long press has fired, never in a release cycle
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rep[i] = state_q[i] && !flip[i] && tick && (hcnt_q[i] == LONG_V) && (rcnt_q[i] == REP_TC);
      rcnt_d[i] = (!state_q[i] || flip[i] || hcnt_q[i] != LONG_V || rep[i]) ? 16'd0 : tick ? rcnt_q[i] + 16'd1 : rcnt_q[i];
    end
  end
`else
  // No repeat hardware; a zero REPEAT_MS would be meaningless anyway
  always_comb rep = {3{REPEAT_MS < 1}} & 3'b000;
`endif
  // Event pulses land in the same cycle the committed state changes
  always_comb begin
    press_d = rise[2:0] | rep;
    release_d = fall[2:0];
    insert_d = rise[3];
    remove_d = fall[3];
  end
  // State registers; reset discards all debounce and hold progress
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
      btn_raw_q <= '0;
      sd_cd_raw_q <= 1'b1;
      state_q <= '0;
      press_q <= '0;
      release_q <= '0;
      long_q <= '0;
      insert_q <= 1'b0;
      remove_q <= 1'b0;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
      for (int i = 0; i < 3; i++) hcnt_q[i] <= '0;
`ifdef IO_BTN_AUTO_REPEAT_EN
      for (int i = 0; i < 3; i++) rcnt_q[i] <= '0;
`endif
    end else begin
      pre_q <= pre_d;
      btn_raw_q <= bus.btn_raw;
      sd_cd_raw_q <= bus.sd_cd_raw;
      state_q <= state_d;
      press_q <= press_d;
      release_q <= release_d;
      long_q <= long_d;
      insert_q <= insert_d;
      remove_q <= remove_d;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
      for (int i = 0; i < 3; i++) hcnt_q[i] <= hcnt_d[i];
`ifdef IO_BTN_AUTO_REPEAT_EN
      for (int i = 0; i < 3; i++) rcnt_q[i] <= rcnt_d[i];
`endif
    end
  end
  assign bus.btn_state = state_q[2:0];
  assign bus.sd_present = state_q[3];
  assign bus.btn_press = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_long = long_q;
  assign bus.sd_insert = insert_q;
  assign bus.sd_remove = remove_q;
endmodule
